// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: multi-cycle MIPS control unit (addu, subu, ori, lw, sw, beq, lui, jal, jr)
// Ports: clk/reset (sync, active-high); op/func from IR; zero = ALU equal flag.
//        PCWrite/IRWrite/RegWrite/MemWrite one-cycle write pulses; IorD, ALUCtrl, ALUSrc, ExtOp,
//        RegDst, MemtoReg, NPCSel datapath selects; state = FSM state; instr_done = last cycle of instr.
module multi_cycle_controller #(
    parameter int MEM_LAT = 0,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IorD,
    output logic [2:0] ALUCtrl,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] NPCSel,
    output logic [2:0] state,
    output logic       instr_done
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXE = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_JAL = 6'b000011;
    localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_JR = 6'b001000;
    state_t st, nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic last, is_r, addu, subu, jr, ori, lui, lw, sw, beq, jal, to_exe;
    logic pcw, irw, rw, mw, done;
    assign is_r = op == OP_R;
    assign addu = is_r && func == F_ADDU;
    assign subu = is_r && func == F_SUBU;
    assign jr = is_r && func == F_JR;
    assign ori = op == OP_ORI;
    assign lui = op == OP_LUI;
    assign lw = op == OP_LW;
    assign sw = op == OP_SW;
    assign beq = op == OP_BEQ;
    assign jal = op == OP_JAL;
    assign to_exe = addu | subu | ori | lui | lw | sw | beq;
    // final cycle of a memory access (FETCH or MEM)
    assign last = wait_cnt == CNT_W'(MEM_LAT);
    always_comb begin
        nxt = FETCH;
        pcw = 1'b0;
        irw = 1'b0;
        rw = 1'b0;
        mw = 1'b0;
        done = 1'b0;
        IorD = 1'b0;
        ALUCtrl = 3'b111;
        ALUSrc = 1'b0;
        ExtOp = 1'b0;
        RegDst = 2'b00;
        MemtoReg = 2'b00;
        NPCSel = 2'b00;
        case (st)
            FETCH: begin
                irw = last;
                pcw = last;
                nxt = last ? DECODE : FETCH;
            end
            DECODE: begin
                RegDst = jal ? 2'b10 : 2'b00;
                MemtoReg = jal ? 2'b11 : 2'b00;
                NPCSel = jal ? 2'b10 : jr ? 2'b11 : 2'b00;
                rw = jal;
                pcw = jal | jr;
                done = !to_exe;
                nxt = to_exe ? EXE : FETCH;
            end
            EXE: begin
                ALUCtrl = (addu | lw | sw) ? 3'b010 : (subu | beq) ? 3'b011 : ori ? 3'b001 : 3'b111;
                ALUSrc = ori | lw | sw;
                ExtOp = ori;
                NPCSel = beq ? 2'b01 : 2'b00;
                pcw = beq & zero;
                done = beq;
                nxt = beq ? FETCH : (lw | sw) ? MEM : WB;
            end
            MEM: begin
                IorD = 1'b1;
                mw = last & sw;
                done = last & sw;
                nxt = !last ? MEM : lw ? WB : FETCH;
            end
            WB: begin
                rw = 1'b1;
                done = 1'b1;
                RegDst = is_r ? 2'b01 : 2'b00;
                MemtoReg = lw ? 2'b10 : lui ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end
    // a reset cycle must never write, even though the decode above may request it
    assign PCWrite = pcw & ~reset;
    assign IRWrite = irw & ~reset;
    assign RegWrite = rw & ~reset;
    assign MemWrite = mw & ~reset;
    assign instr_done = done & ~reset;
    assign state = st;
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= FETCH;
            wait_cnt <= '0;
        end else begin
            st <= nxt;
            wait_cnt <= ((st == FETCH || st == MEM) && !last) ? wait_cnt + CNT_W'(1) : '0;
        end
    end
endmodule
